// File: rtl/control_flag_writer.sv
// NZCV producer: computes flags for the execute-stage ALU op, stages them one
// cycle, commits to the architectural flags and keeps a one-entry shadow copy.
module control_flag_writer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             setflags,
    input  logic             condex,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
    input  logic             save,
    input  logic             restore,
    output logic [3:0]       flags,
    output logic [3:0]       flags_fwd,
    output logic             pend_valid
);
    localparam int MSB = WIDTH - 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ORR = 2'b11;

    logic [3:0]       pend_flags;
    logic [3:0]       shadow;
    logic [3:0]       new_flags;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             v_new;
    logic             cap;

    assign flags_fwd = pend_valid ? pend_flags : flags;
    assign cap       = valid & setflags & condex & ~flush & ~stall & ~restore;

    // Logic ops keep C/V from the forwarded view so a flag-setter one cycle
    // ahead is already visible.
    always_comb begin
        sum   = '0;
        res   = '0;
        c_new = flags_fwd[1];
        v_new = flags_fwd[0];
        case (alu_op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                res   = sum[MSB:0];
                c_new = sum[WIDTH];
                v_new = (a[MSB] == b[MSB]) & (res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // carry out of a + ~b + 1 is the inverted borrow
                sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                res   = sum[MSB:0];
                c_new = sum[WIDTH];
                v_new = (a[MSB] != b[MSB]) & (res[MSB] != a[MSB]);
            end
            OP_AND:  res = a & b;
            OP_ORR:  res = a | b;
            default: res = '0;
        endcase
        new_flags = {res[MSB], (res == '0), c_new, v_new};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags      <= '0;
            shadow     <= '0;
            pend_valid <= 1'b0;
            pend_flags <= '0;
        end else begin
            if (save)
                shadow <= flags_fwd;
            if (restore) begin
                flags      <= shadow;
                pend_valid <= 1'b0;
            end else if (!stall) begin
                if (pend_valid)
                    flags <= pend_flags;
                pend_valid <= cap;
                if (cap)
                    pend_flags <= new_flags;
            end
        end
    end
endmodule

// File: tb/tb_control_flag_writer.sv
// Random + directed bench for control_flag_writer against a behavioural model.
module tb_control_flag_writer;
    logic        clk = 1'b0;
    logic        rst_n, valid, setflags, condex, stall, flush, save, restore;
    logic [1:0]  alu_op;
    logic [31:0] a, b;
    logic [3:0]  flags, flags_fwd;
    logic        pend_valid;

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic [3:0] m_fl, m_sh, m_pf;
    logic       m_pv;

    control_flag_writer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .setflags(setflags),
        .condex(condex), .alu_op(alu_op), .a(a), .b(b), .stall(stall),
        .flush(flush), .save(save), .restore(restore), .flags(flags),
        .flags_fwd(flags_fwd), .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [3:0] fwd);
        longint     ux = longint'(x), uy = longint'(y);
        longint     sx = longint'($signed(x)), sy = longint'($signed(y));
        longint     s;
        logic [31:0] r;
        logic        c = fwd[1], v = fwd[0];
        case (op)
            2'b00: begin
                r = 32'(ux + uy);
                c = (ux + uy) > 64'sh0FFFFFFFF;
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b01: begin
                r = 32'(ux - uy);
                c = ux >= uy;
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b10:   r = x & y;
            default: r = x | y;
        endcase
        return {r[31], r == 32'd0, c, v};
    endfunction

    // drive one cycle, advance the model across the edge, compare after it
    task automatic step(input logic rs_n, input logic v, input logic s, input logic cx,
                        input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic st, input logic fl, input logic sv, input logic rs);
        logic [3:0] fwd, comp;
        logic       cp;
        rst_n = rs_n; valid = v; setflags = s; condex = cx; alu_op = op; a = x; b = y;
        stall = st; flush = fl; save = sv; restore = rs;
        fwd  = m_pv ? m_pf : m_fl;
        comp = ref_flags(op, x, y, fwd);
        cp   = v & s & cx & ~fl & ~st & ~rs;
        @(posedge clk);
        if (!rs_n) begin
            m_fl = 0; m_sh = 0; m_pv = 0; m_pf = 0;
        end else begin
            logic [3:0] nsh;
            nsh = sv ? fwd : m_sh;
            if (rs) begin
                m_fl = m_sh; m_pv = 0;
            end else if (!st) begin
                if (m_pv) m_fl = m_pf;
                m_pv = cp;
                if (cp) m_pf = comp;
            end
            m_sh = nsh;
        end
        #1;
        check("flags", 32'(flags), 32'(m_fl));
        check("flags_fwd", 32'(flags_fwd), 32'(m_pv ? m_pf : m_fl));
        check("pend_valid", 32'(pend_valid), 32'(m_pv));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cap(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        step(1, 1, 1, 1, op, x, y, 0, 0, 0, 0);
    endtask

    initial begin
        m_fl = 'x; m_sh = 'x; m_pf = 'x; m_pv = 'x;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_fwd", 32'(flags_fwd), 0);

        // ADD overflow into sign bit
        cap(2'b00, 32'h7FFFFFFF, 32'd1);
        check("add_fwd", 32'(flags_fwd), 32'b1001);
        check("add_flags_old", 32'(flags), 0);
        idle();
        check("add_commit", 32'(flags), 32'b1001);

        // back-to-back SUBs
        cap(2'b01, 32'd5, 32'd5);
        cap(2'b01, 32'd3, 32'd5);
        check("sub_eq_commit", 32'(flags), 32'b0110);
        idle();
        check("sub_lt_commit", 32'(flags), 32'b1000);

        // ADD then AND keeps ADD's C/V via forwarding
        cap(2'b00, 32'hFFFFFFFF, 32'd1);
        cap(2'b10, 32'h80000000, 32'hFFFFFFFF);
        idle();
        check("and_keeps_cv", 32'(flags), 32'b1010);

        // blocked captures
        step(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 0, 0, 0, 0);
        check("condex_blk", 32'(pend_valid), 0);
        step(1, 1, 1, 1, 2'b00, 32'd0, 32'd0, 0, 1, 0, 0);
        check("flush_blk", 32'(flags), 32'b1010);

        // capture then stall for 3 cycles
        cap(2'b01, 32'd5, 32'd5);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("stall_hold", 32'(flags), 32'b1010);
        idle();
        check("stall_release", 32'(flags), 32'b0110);

        // save / restore
        cap(2'b00, 32'h7FFFFFFF, 32'd1);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cap(2'b00, 32'hFFFFFFFF, 32'd1);
        idle();
        check("pre_restore", 32'(flags), 32'b0110);
        step(1, 1, 1, 1, 2'b01, 32'd3, 32'd5, 0, 0, 0, 1);
        check("restore_flags", 32'(flags), 32'b1001);
        check("restore_drop", 32'(pend_valid), 0);
        cap(2'b01, 32'd5, 32'd5);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("swap_flags", 32'(flags), 32'b1001);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        check("swap_shadow", 32'(flags), 32'b0110);

        // reset with pending update and nonzero shadow
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cap(2'b00, 32'h7FFFFFFF, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("rst_mid_flags", 32'(flags), 0);
        check("rst_mid_pv", 32'(pend_valid), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_shadow", 32'(flags), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                0: x = 32'h80000000;
                1: y = x;
                2: y = 32'hFFFFFFFF - x;
                default: ;
            endcase
            step(($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0), 2'($urandom), x, y,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/control_flag_writer.md
# control_flag_writer

Producer side of the NZCV condition-flag interface: computes N, Z, C, V for the current ALU operation, stages the update through one pipeline register and commits it to the architectural flags register consumed by the condition-check logic. Also provides a forwarded flag view, so a conditional instruction one cycle behind a flag-setting instruction evaluates against the newest flags. Also provides a one-entry shadow for save/restore around exceptions. Sits in the execute/writeback boundary of the processor control path.

## Interface
- WIDTH, 32, ALU operand width (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid  in  1  execute-stage instruction valid
- setflags  in  1  instruction requests flag update (S bit)
- condex  in  1  instruction's condition passed (from condition check)
- alu_op  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- stall  in  1  freeze pipeline register
- flush  in  1  kill execute-stage instruction
- save  in  1  copy forwarded flags into shadow
- restore  in  1  load shadow into architectural flags
- flags  out  4  architectural flags {N,Z,C,V}: [3]=N, [2]=Z, [1]=C, [0]=V
- flags_fwd  out  4  pend_valid ? pend_flags : flags (combinational)
- pend_valid  out  1  staged update awaiting commit

## Operation
- Flag computation (combinational, from a, b, alu_op):
  - ADD: r = a+b. C = carry out of bit WIDTH-1. V = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - SUB: r = a-b. C = 1 when no borrow (a ≥ b unsigned). V = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - AND/ORR: r = a&b / a|b. C and V unchanged, taken from flags_fwd.
  - All ops: N = r[msb]. Z = (r==0).
- Capture condition: cap = valid & setflags & condex & ~flush & ~stall & ~restore.
- Pipeline register:
  - Commit path: if pend_valid & ~stall, then flags <= pend_flags.
  - Next staging state: pend_valid <= cap; on cap, pend_flags <= computed flags.
  - While stall=1: pend_valid, pend_flags and flags all hold.
- Restore (priority over everything except reset):
  - Next cycle: flags <= shadow, pend_valid <= 0. Any pending update is discarded and the same-cycle capture is dropped.
  - Stall does not block restore.
- Save: shadow <= flags_fwd, regardless of stall.
  - Save and restore in the same cycle: swap, i.e. shadow <= flags_fwd and flags <= old shadow.
- Flush: blocks only the same-cycle capture. An already-staged update still commits.
- Back-to-back captures: each cycle's capture overwrites pend_flags while the previous value commits, giving a continuous stream.

## Timing
- Reset (rst_n=0 at edge): flags=4'b0000, shadow=4'b0000, pend_valid=0, pend_flags=0; flags_fwd=0.
- Capture at edge t:
  - flags_fwd shows the new value after edge t.
  - flags shows it after edge t+1, assuming no stall.
- Logic-op C/V source is flags_fwd, so chained ADD→AND in consecutive cycles keeps the ADD's C/V.
- Restore at edge t: flags=shadow after t; flags_fwd=shadow after t.
- Reset asserted mid-stall or with a pending update: all state clears; the pending update is lost.
- All outputs are registered except flags_fwd.

## Test plan
- Reset, then ADD a=0x7FFFFFFF b=1, setflags=1, condex=1:
  - after 1 edge: flags_fwd=4'b1001 (N,V), flags still 0.
  - after 2 edges: flags=4'b1001.
- SUB a=5 b=5 → 4'b0110 (Z,C). Then SUB a=3 b=5 → 4'b1000. Commit back-to-back on consecutive edges.
- Sequence ADD 0xFFFFFFFF+1 (→4'b0110), then AND a=0x80000000 b=0xFFFFFFFF next cycle → flags=4'b1010 (C kept, V kept 0).
- Capture blocked:
  - condex=0 or flush=1 with setflags=1 → pend_valid stays 0, flags unchanged.
  - Capture then stall=1 for 3 cycles → flags unchanged until the cycle after stall drops.
- Exception save/restore:
  - flags=4'b1001, save=1; then ADD producing 4'b0110 commits; then restore=1 together with a new capture → flags=4'b1001, pend_valid=0, capture dropped.
  - save+restore in the same cycle swaps flags and shadow.
- Drive rst_n=0 with pend_valid=1 and shadow≠0 → all outputs 0 after the edge.
